// File: rtl/stoch_dec_mat.sv
// Matrix stochastic-to-binary decoder: counts ones per element over a window of
// 2^WIN_LOG2 qualified cycles and presents the counts through a valid/ready handshake.
module stoch_dec_mat #(
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 3,
    parameter int WIN_LOG2 = 8
) (
    input  logic                                             CLK,
    input  logic                                             RST,
    input  logic                                             START,
    input  logic                                             EN,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                A,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0][WIN_LOG2:0]    Y,
    output logic                                             VALID,
    input  logic                                             READY,
    output logic                                             BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIN_LOG2-1:0]                          win_q, win_d;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][WIN_LOG2:0] cnt_q, cnt_d;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][WIN_LOG2:0] y_q, y_d;

    logic last_bit;
    assign last_bit = (win_q == {WIN_LOG2{1'b1}});

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        y_d     = y_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = ACCUM;
                    win_d   = '0;
                    cnt_d   = '0;
                end
            end

            ACCUM: begin
                if (EN) begin
                    win_d = win_q + 1'b1;
                    for (int i = 0; i < NUM_ROWS; i++) begin
                        for (int j = 0; j < NUM_COLS; j++) begin
                            cnt_d[i][j] = cnt_q[i][j] + {{WIN_LOG2{1'b0}}, A[i][j]};
                        end
                    end
                    // The final qualified bit is folded straight into the result.
                    if (last_bit) begin
                        y_d     = cnt_d;
                        state_d = HOLD;
                    end
                end
            end

            HOLD: begin
                if (READY) begin
                    if (START) begin
                        state_d = ACCUM;
                        win_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            win_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign Y     = y_q;
    assign VALID = (state_q == HOLD);
    assign BUSY  = (state_q == ACCUM);

endmodule

// File: tb/tb_stoch_dec_mat.sv
// Directed self-checking bench for stoch_dec_mat with a 2x2 matrix and 8-bit window.
module tb_stoch_dec_mat;

    localparam int R = 2;
    localparam int C = 2;
    localparam int W = 3;

    logic                     CLK;
    logic                     RST;
    logic                     START;
    logic                     EN;
    logic [R-1:0][C-1:0]      A;
    logic [R-1:0][C-1:0][W:0] Y;
    logic                     VALID;
    logic                     READY;
    logic                     BUSY;

    int checks   = 0;
    int failures = 0;

    stoch_dec_mat #(
        .NUM_ROWS(R),
        .NUM_COLS(C),
        .WIN_LOG2(W)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .START(START),
        .EN   (EN),
        .A    (A),
        .Y    (Y),
        .VALID(VALID),
        .READY(READY),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, sample at the next falling edge.
    task automatic cycle(input logic s, input logic e, input logic [3:0] a, input logic r);
        START = s;
        EN    = e;
        A     = a;
        READY = r;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; EN = 1'b0; A = '0; READY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_y", 32'(Y), 32'h0);
        check("rst_valid", 32'(VALID), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        RST = 1'b0;
        @(negedge CLK);

        // Window 1: all ones for 8 qualified cycles
        cycle(1'b0, 1'b1, 4'hF, 1'b0);
        check("idle_ignores_en", 32'(BUSY), 32'h0);
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        check("start_busy", 32'(BUSY), 32'h1);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, 4'hF, 1'b0);
            if (k == 6) check("ones_valid_early", 32'(VALID), 32'h0);
        end
        check("ones_valid", 32'(VALID), 32'h1);
        check("ones_busy_hold", 32'(BUSY), 32'h0);
        check("ones_y", 32'(Y), 32'h8888);
        cycle(1'b0, 1'b0, 4'h0, 1'b1);
        check("ack_valid_drop", 32'(VALID), 32'h0);
        check("ack_busy", 32'(BUSY), 32'h0);
        check("idle_keeps_y", 32'(Y), 32'h8888);

        // Window 2: per-element patterns, A bits = {a11, a10, a01, a00}
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, {k == 0, k == 7, (k % 2) == 0, 1'b0}, 1'b0);
        end
        check("pattern_valid", 32'(VALID), 32'h1);
        check("pattern_y", 32'(Y), 32'h1140);

        // Backpressure while A and START toggle
        for (int k = 0; k < 5; k++) begin
            cycle(k[0], k[0], k[0] ? 4'hF : 4'h5, 1'b0);
            check("bp_valid", 32'(VALID), 32'h1);
            check("bp_y", 32'(Y), 32'h1140);
        end
        cycle(1'b0, 1'b0, 4'h0, 1'b1);
        check("bp_release_valid", 32'(VALID), 32'h0);
        check("bp_release_busy", 32'(BUSY), 32'h0);

        // Asynchronous reset after 5 bits of an all-ones window
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 4'hF, 1'b0);
        #2 RST = 1'b1;
        #1;
        check("midrst_y", 32'(Y), 32'h0);
        check("midrst_valid", 32'(VALID), 32'h0);
        check("midrst_busy", 32'(BUSY), 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, 4'hF, 1'b0);
            if (k == 6) check("post_rst_valid_early", 32'(VALID), 32'h0);
        end
        check("post_rst_valid", 32'(VALID), 32'h1);
        check("post_rst_y", 32'(Y), 32'h8888);
        cycle(1'b0, 1'b0, 4'h0, 1'b1);
        check("post_rst_ack", 32'(VALID), 32'h0);

        // EN gaps: 8 qualified bits over 15 cycles; a00 is one only on EN cycles
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            cycle(1'b0, (k % 2) == 0, ((k % 2) == 0) ? 4'h1 : 4'hE, 1'b0);
            if (k == 13) check("gap_valid_early", 32'(VALID), 32'h0);
        end
        check("gap_valid", 32'(VALID), 32'h1);
        check("gap_y", 32'(Y), 32'h0008);

        // Back-to-back: accept and restart in the same HOLD cycle
        cycle(1'b1, 1'b1, 4'hF, 1'b1);
        check("b2b_busy", 32'(BUSY), 32'h1);
        check("b2b_valid", 32'(VALID), 32'h0);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, 4'h0, 1'b0);
            if (k == 6) check("b2b_valid_early", 32'(VALID), 32'h0);
        end
        check("b2b_valid_done", 32'(VALID), 32'h1);
        check("b2b_y", 32'(Y), 32'h0000);
        cycle(1'b0, 1'b0, 4'h0, 1'b1);
        check("b2b_ack", 32'(VALID), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
